dbg_abs_cmd_ctrl: RTL

Abstract-command sequencer inside the debug module (DM), between the DMI register file and the halted hart's park loop. It accepts `command` writes and `abstractauto` triggers, and validates them against the supported subset. It hands off valid commands to the hart through a go/going/ack handshake and owns `abstractcs.busy`/`cmderr`. It also sequences resume requests so that they never overlap an abstract command.

---
 rtl/dbg_abs_cmd_ctrl_pkg.sv | 43 ++++
 rtl/dbg_abs_cmd_ctrl_if.sv | 36 +++
 rtl/dbg_abs_cmd_ctrl_chk.sv | 43 ++++
 rtl/dbg_abs_cmd_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/dbg_abs_cmd_ctrl_pkg.sv
// Debug-module shared types: abstract command layout, cmderr codes
// and the abstract-command sequencer state encoding.
package dbg_pkg;

   localparam logic [7:0] CMD_ACCESS_REG = 8'h00;

   typedef struct packed {
      logic [7:0]  cmdtype;
      logic [23:0] control;
   } command_t;

   typedef struct packed {
      logic        zero1;
      logic [2:0]  aarsize;
      logic        aarpostincrement;
      logic        postexec;
      logic        transfer;
      logic        write;
      logic [15:0] regno;
   } ac_ar_cmd_t;

   typedef enum logic [2:0] {
      CmdErrNone         = 3'd0,
      CmdErrBusy         = 3'd1,
      CmdErrNotSupported = 3'd2,
      CmdErrException    = 3'd3,
      CmdErrHaltResume   = 3'd4,
      CmdErrBus          = 3'd5,
      CmdErrOther        = 3'd7
   } cmderr_e;

   typedef enum logic [1:0] {
      IDLE,
      GO,
      EXEC,
      RESUME
   } abs_state_e;

   localparam logic [15:0] REGNO_CSR_MAX  = 16'h0FFF;
   localparam logic [15:0] REGNO_GPR_BASE = 16'h1000;
   localparam logic [15:0] REGNO_FPR_BASE = 16'h1020;

endpackage

// File: rtl/dbg_abs_cmd_ctrl_if.sv
// DMI-side and hart-side signal bundle of the abstract-command sequencer.
interface dbg_abs_cmd_ctrl_if;

   logic        dmactive_i;
   logic        cmd_vld_i;
   logic [31:0] cmd_i;
   logic        autoexec_i;
   logic        data_acc_i;
   logic [2:0]  cmderr_clr_i;
   logic        hart_halted_i;
   logic        going_i;
   logic        done_i;
   logic        exc_i;
   logic        resume_req_i;
   logic        resumeack_i;
   logic        go_o;
   logic        resume_o;
   logic        busy_o;
   logic [2:0]  cmderr_o;
   logic [23:0] ar_cmd_o;

   modport master (
      output dmactive_i, cmd_vld_i, cmd_i, autoexec_i, data_acc_i,
      output cmderr_clr_i, hart_halted_i, going_i, done_i, exc_i,
      output resume_req_i, resumeack_i,
      input  go_o, resume_o, busy_o, cmderr_o, ar_cmd_o
   );

   modport slave (
      input  dmactive_i, cmd_vld_i, cmd_i, autoexec_i, data_acc_i,
      input  cmderr_clr_i, hart_halted_i, going_i, done_i, exc_i,
      input  resume_req_i, resumeack_i,
      output go_o, resume_o, busy_o, cmderr_o, ar_cmd_o
   );

endinterface

// File: rtl/dbg_abs_cmd_ctrl_chk.sv
// Combinational validator for abstract commands against the
// supported AccessRegister subset.
module dbg_abs_cmd_chk
   import dbg_pkg::*;
(
   input  command_t cmd_i,
   input  logic     halted_i,
   output cmderr_e  err_o,
   output logic     vld_o
);

   localparam logic [15:0] REGNO_FPR_MAX = REGNO_FPR_BASE + 16'h001F;

   ac_ar_cmd_t ar;
   logic       size_ok;
   logic       regno_ok;
   logic       unused_bits;

   assign ar          = ac_ar_cmd_t'(cmd_i.control);
   assign unused_bits = ^{ar.zero1, ar.postexec, ar.write};

   always_comb begin
      size_ok  = (ar.aarsize == 3'd2) || (ar.aarsize == 3'd3);
      regno_ok = (ar.regno <= REGNO_CSR_MAX)
              || ((ar.regno >= REGNO_GPR_BASE) && (ar.regno < REGNO_FPR_BASE))
              || ((ar.regno >= REGNO_FPR_BASE) && (ar.regno <= REGNO_FPR_MAX));
      err_o    = CmdErrNone;
      // first failing check wins; halt state is only looked at last
      if (cmd_i.cmdtype != CMD_ACCESS_REG) begin
         err_o = CmdErrNotSupported;
      end else if (ar.aarpostincrement) begin
         err_o = CmdErrNotSupported;
      end else if (ar.transfer && !size_ok) begin
         err_o = CmdErrNotSupported;
      end else if (ar.transfer && !regno_ok) begin
         err_o = CmdErrNotSupported;
      end else if (!halted_i) begin
         err_o = CmdErrHaltResume;
      end
      vld_o = (err_o == CmdErrNone);
   end

endmodule

// File: rtl/dbg_abs_cmd_ctrl.sv
// Abstract-command sequencer: validates commands, drives the go/going/ack
// handshake with the parked hart and keeps resume out of command windows.
module dbg_abs_cmd_ctrl
   import dbg_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic              clk_i,
   input  logic              rst_i,
   dbg_abs_cmd_ctrl_if.slave bus
);

   localparam int unsigned WD_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC == 0) ? '0 : WD_W'(TIMEOUT_CYC - 1);
   localparam logic [WD_W-1:0] WD_SAT  = '1;

   abs_state_e      state_q, state_d;
   logic [2:0]      cmderr_q, cmderr_d;
   logic [23:0]     ar_q, ar_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            go_q, go_d;
   logic            busy_q, busy_d;
   logic            resume_q, resume_d;

   command_t chk_cmd;
   cmderr_e  chk_err;
   logic     chk_vld;
   logic     launch;
   logic     access;
   logic     err_none;

   // autoexec replays the latched control field as an AccessRegister
   assign chk_cmd = bus.cmd_vld_i ? command_t'(bus.cmd_i)
                                  : command_t'({CMD_ACCESS_REG, ar_q});

   dbg_abs_cmd_chk u_chk (
      .cmd_i    (chk_cmd),
      .halted_i (bus.hart_halted_i),
      .err_o    (chk_err),
      .vld_o    (chk_vld)
   );

   always_comb begin
      state_d  = state_q;
      cmderr_d = cmderr_q & ~bus.cmderr_clr_i;
      ar_d     = ar_q;
      wd_d     = wd_q;
      launch   = bus.cmd_vld_i | bus.autoexec_i;
      access   = launch | bus.data_acc_i;
      err_none = (cmderr_q == CmdErrNone);
      unique case (state_q)
         IDLE: begin
            if (launch) begin
               if (err_none) begin
                  if (chk_vld) begin
                     ar_d    = chk_cmd.control;
                     state_d = GO;
                  end else begin
                     cmderr_d = chk_err;
                  end
               end
            end else if (bus.resume_req_i && bus.hart_halted_i) begin
               state_d = RESUME;
            end
         end
         GO: begin
            if (access && err_none) cmderr_d = CmdErrBusy;
            if (bus.going_i) begin
               state_d = EXEC;
               wd_d    = '0;
            end
         end
         EXEC: begin
            if (access && err_none) cmderr_d = CmdErrBusy;
            if (bus.exc_i) begin
               state_d = IDLE;
               if (err_none) cmderr_d = CmdErrException;
            end else if (bus.done_i) begin
               state_d = IDLE;
            end else if ((TIMEOUT_CYC != 0) && (wd_q == WD_LAST)) begin
               state_d = IDLE;
               if (err_none) cmderr_d = CmdErrOther;
            end else if (wd_q != WD_SAT) begin
               wd_d = wd_q + 1'b1;
            end
         end
         RESUME: begin
            if (bus.resumeack_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (!bus.dmactive_i) begin
         state_d  = IDLE;
         cmderr_d = CmdErrNone;
         ar_d     = '0;
         wd_d     = '0;
      end
      go_d     = (state_d == GO);
      busy_d   = (state_d == GO) || (state_d == EXEC);
      resume_d = (state_d == RESUME);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cmderr_q <= CmdErrNone;
         ar_q     <= '0;
         wd_q     <= '0;
         go_q     <= 1'b0;
         busy_q   <= 1'b0;
         resume_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmderr_q <= cmderr_d;
         ar_q     <= ar_d;
         wd_q     <= wd_d;
         go_q     <= go_d;
         busy_q   <= busy_d;
         resume_q <= resume_d;
      end
   end

   assign bus.go_o     = go_q;
   assign bus.resume_o = resume_q;
   assign bus.busy_o   = busy_q;
   assign bus.cmderr_o = cmderr_q;
   assign bus.ar_cmd_o = ar_q;

endmodule
